// File: rtl/mem_pkg.sv
// Shared memory-subsystem types and default widths used by the RAM, the CPU and the
// RAM arbiter.
package mem_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_ADDR_WIDTH = 9;

    typedef enum logic {
        CPU    = 1'b0,
        LOADER = 1'b1
    } master_e;

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant between the CPU and the loader. The grant is combinational;
// the last winner is remembered so that the other master wins the next tie.
module rr_arbiter2
    import mem_pkg::*;
(
    input  logic clk,
    input  logic resetN,
    input  logic en,
    input  logic cpu_req,
    input  logic ld_req,
    output logic cpu_gnt,
    output logic ld_gnt
);

    master_e rr_last_q;

    always_comb begin
        cpu_gnt = 1'b0;
        ld_gnt  = 1'b0;
        if (en && resetN) begin
            if (cpu_req && ld_req) begin
                cpu_gnt = (rr_last_q == LOADER);
                ld_gnt  = (rr_last_q == CPU);
            end else begin
                cpu_gnt = cpu_req;
                ld_gnt  = ld_req;
            end
        end
    end

    // Reset to LOADER so the CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            rr_last_q <= LOADER;
        end else if (cpu_gnt) begin
            rr_last_q <= CPU;
        end else if (ld_gnt) begin
            rr_last_q <= LOADER;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the CPU-side RAM port between the CPU and the loader, after optionally zeroing
// the screen region of RAM once reset is released.
module ram_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned SCREEN_BASE    = 0,
    parameter int unsigned SCREEN_WORDS   = 384,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_stall,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  ld_req,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_wdata,
    output logic                  ld_gnt,
    output logic                  ld_rvalid,
    output logic [DATA_WIDTH-1:0] ld_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  clear_busy
);

    localparam int unsigned CNT_W = (SCREEN_WORDS > 0) ? $clog2(SCREEN_WORDS + 1) : 1;
    localparam arb_state_e RESET_STATE =
        (CLEAR_ON_RESET != 0 && SCREEN_WORDS != 0) ? CLEAR : ARB;

    arb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      clr_cnt_q, clr_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  cpu_rvalid_q, ld_rvalid_q;
    logic                  cpu_gnt;

    rr_arbiter2 u_rr_arbiter2 (
        .clk     (clk),
        .resetN  (resetN),
        .en      (state_q == ARB),
        .cpu_req (cpu_req),
        .ld_req  (ld_req),
        .cpu_gnt (cpu_gnt),
        .ld_gnt  (ld_gnt)
    );

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        ram_we     = 1'b0;
        ram_addr   = addr_q;
        ram_wdata  = '0;
        clear_busy = 1'b0;
        unique case (state_q)
            CLEAR: begin
                ram_we     = 1'b1;
                ram_addr   = ADDR_WIDTH'(SCREEN_BASE) + ADDR_WIDTH'(clr_cnt_q);
                clear_busy = 1'b1;
                clr_cnt_d  = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CNT_W'(SCREEN_WORDS - 1)) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (cpu_gnt) begin
                    ram_we    = cpu_we;
                    ram_addr  = cpu_addr;
                    ram_wdata = cpu_wdata;
                end else if (ld_gnt) begin
                    ram_we    = ld_we;
                    ram_addr  = ld_addr;
                    ram_wdata = ld_wdata;
                end
            end
            default: ;
        endcase
        // Nothing may reach the RAM while reset is held, whatever the state register holds.
        if (!resetN) begin
            ram_we    = 1'b0;
            ram_addr  = '0;
            ram_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q      <= RESET_STATE;
            clr_cnt_q    <= '0;
            addr_q       <= '0;
            cpu_rvalid_q <= 1'b0;
            ld_rvalid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            addr_q       <= ram_addr;
            cpu_rvalid_q <= cpu_gnt & ~cpu_we;
            ld_rvalid_q  <= ld_gnt & ~ld_we;
        end
    end

    assign cpu_stall  = cpu_req & ~cpu_gnt;
    assign cpu_rvalid = cpu_rvalid_q;
    assign ld_rvalid  = ld_rvalid_q;
    assign cpu_rdata  = ram_rdata;
    assign ld_rdata   = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one instance with a 4-word clear at 0x10 backed by a
// behavioural RAM, and one instance with the clear disabled.
module tb_ram_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 9;

    logic          clk = 1'b0;
    logic          resetN;
    logic          cpu_req, cpu_we, ld_req, ld_we;
    logic [AW-1:0] cpu_addr, ld_addr;
    logic [DW-1:0] cpu_wdata, ld_wdata;
    logic          cpu_stall, cpu_rvalid, ld_gnt, ld_rvalid, ram_we, clear_busy;
    logic [DW-1:0] cpu_rdata, ld_rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    logic          b_cpu_req, b_cpu_we, b_ld_req, b_ld_we;
    logic [AW-1:0] b_cpu_addr, b_ld_addr, b_ram_addr;
    logic [DW-1:0] b_cpu_wdata, b_ld_wdata, b_ram_rdata;
    logic          b_cpu_stall, b_cpu_rvalid, b_ld_gnt, b_ld_rvalid, b_ram_we, b_clear_busy;
    logic [DW-1:0] b_cpu_rdata, b_ld_rdata, b_ram_wdata;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    ram_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SCREEN_BASE(16), .SCREEN_WORDS(4),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .resetN(resetN),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .clear_busy(clear_busy)
    );

    ram_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SCREEN_BASE(16), .SCREEN_WORDS(4),
        .CLEAR_ON_RESET(0)
    ) dut_b (
        .clk(clk), .resetN(resetN),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr),
        .cpu_wdata(b_cpu_wdata), .cpu_stall(b_cpu_stall), .cpu_rvalid(b_cpu_rvalid),
        .cpu_rdata(b_cpu_rdata),
        .ld_req(b_ld_req), .ld_we(b_ld_we), .ld_addr(b_ld_addr), .ld_wdata(b_ld_wdata),
        .ld_gnt(b_ld_gnt), .ld_rvalid(b_ld_rvalid), .ld_rdata(b_ld_rdata),
        .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_we(b_ram_we),
        .ram_rdata(b_ram_rdata), .clear_busy(b_clear_busy)
    );

    // Synchronous RAM: write in the address cycle, read data one cycle later.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic test_reset();
        resetN = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h040; cpu_wdata = 16'h0055;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 9'h050; ld_wdata = 16'h0066;
        b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = '0; b_cpu_wdata = '0;
        b_ld_req = 1'b0; b_ld_we = 1'b0; b_ld_addr = '0; b_ld_wdata = '0;
        b_ram_rdata = '0;
        repeat (2) @(negedge clk);
        vecs++; if (ram_we !== 1'b0) begin errs++; $display("FAIL rst_we: got %b want 0", ram_we); end
        vecs++; if (ram_addr !== 9'h000) begin errs++; $display("FAIL rst_addr: got %h want 000", ram_addr); end
        vecs++; if (ram_wdata !== 16'h0000) begin errs++; $display("FAIL rst_wdata: got %h want 0000", ram_wdata); end
        vecs++; if (ld_gnt !== 1'b0) begin errs++; $display("FAIL rst_ld_gnt: got %b want 0", ld_gnt); end
        vecs++; if (cpu_stall !== 1'b1) begin errs++; $display("FAIL rst_stall: got %b want 1", cpu_stall); end
        vecs++; if (cpu_rvalid !== 1'b0) begin errs++; $display("FAIL rst_cpu_rvalid: got %b want 0", cpu_rvalid); end
        vecs++; if (ld_rvalid !== 1'b0) begin errs++; $display("FAIL rst_ld_rvalid: got %b want 0", ld_rvalid); end
        vecs++; if (clear_busy !== 1'b1) begin errs++; $display("FAIL rst_busy: got %b want 1", clear_busy); end
        vecs++; if (b_clear_busy !== 1'b0) begin errs++; $display("FAIL rst_b_busy: got %b want 0", b_clear_busy); end
        vecs++; if (b_ram_we !== 1'b0) begin errs++; $display("FAIL rst_b_we: got %b want 0", b_ram_we); end
    endtask

    task automatic test_clear();
        resetN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vecs++; if (ram_we !== 1'b1) begin errs++; $display("FAIL clr_we[%0d]: got %b want 1", i, ram_we); end
            vecs++; if (ram_addr !== 9'(16 + i)) begin errs++; $display("FAIL clr_addr[%0d]: got %h want %h", i, ram_addr, 9'(16 + i)); end
            vecs++; if (ram_wdata !== 16'h0000) begin errs++; $display("FAIL clr_wdata[%0d]: got %h want 0000", i, ram_wdata); end
            vecs++; if (cpu_stall !== 1'b1) begin errs++; $display("FAIL clr_stall[%0d]: got %b want 1", i, cpu_stall); end
            vecs++; if (ld_gnt !== 1'b0) begin errs++; $display("FAIL clr_ld_gnt[%0d]: got %b want 0", i, ld_gnt); end
            vecs++; if (clear_busy !== 1'b1) begin errs++; $display("FAIL clr_busy[%0d]: got %b want 1", i, clear_busy); end
            @(negedge clk);
        end
    endtask

    // Both masters keep requesting writes: CPU wins the first tie, then they alternate.
    task automatic test_contention();
        logic          exp_cpu;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
        for (int k = 0; k < 4; k++) begin
            exp_cpu   = (k % 2 == 0);
            exp_addr  = exp_cpu ? 9'h040 : 9'h050;
            exp_wdata = exp_cpu ? 16'h0055 : 16'h0066;
            #1;
            vecs++; if (clear_busy !== 1'b0) begin errs++; $display("FAIL arb_busy[%0d]: got %b want 0", k, clear_busy); end
            vecs++; if (cpu_stall !== !exp_cpu) begin errs++; $display("FAIL arb_stall[%0d]: got %b want %b", k, cpu_stall, !exp_cpu); end
            vecs++; if (ld_gnt !== !exp_cpu) begin errs++; $display("FAIL arb_ld_gnt[%0d]: got %b want %b", k, ld_gnt, !exp_cpu); end
            vecs++; if (ram_we !== 1'b1) begin errs++; $display("FAIL arb_we[%0d]: got %b want 1", k, ram_we); end
            vecs++; if (ram_addr !== exp_addr) begin errs++; $display("FAIL arb_addr[%0d]: got %h want %h", k, ram_addr, exp_addr); end
            vecs++; if (ram_wdata !== exp_wdata) begin errs++; $display("FAIL arb_wdata[%0d]: got %h want %h", k, ram_wdata, exp_wdata); end
            @(negedge clk);
        end
        cpu_req = 1'b0;
        ld_req  = 1'b0;
        #1;
        vecs++; if (ram_we !== 1'b0) begin errs++; $display("FAIL idle_we: got %b want 0", ram_we); end
        vecs++; if (ram_addr !== 9'h050) begin errs++; $display("FAIL idle_addr_hold: got %h want 050", ram_addr); end
        vecs++; if (ld_gnt !== 1'b0) begin errs++; $display("FAIL idle_ld_gnt: got %b want 0", ld_gnt); end
        vecs++; if (cpu_stall !== 1'b0) begin errs++; $display("FAIL idle_stall: got %b want 0", cpu_stall); end
        @(negedge clk);
    endtask

    task automatic test_read_latency();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h005;
        #1;
        vecs++; if (ram_we !== 1'b0) begin errs++; $display("FAIL rd_we: got %b want 0", ram_we); end
        vecs++; if (ram_addr !== 9'h005) begin errs++; $display("FAIL rd_addr: got %h want 005", ram_addr); end
        vecs++; if (cpu_stall !== 1'b0) begin errs++; $display("FAIL rd_stall: got %b want 0", cpu_stall); end
        vecs++; if (cpu_rvalid !== 1'b0) begin errs++; $display("FAIL rd_early_rvalid: got %b want 0", cpu_rvalid); end
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        vecs++; if (cpu_rvalid !== 1'b1) begin errs++; $display("FAIL rd_rvalid: got %b want 1", cpu_rvalid); end
        vecs++; if (cpu_rdata !== 16'h1234) begin errs++; $display("FAIL rd_rdata: got %h want 1234", cpu_rdata); end
        vecs++; if (ld_rvalid !== 1'b0) begin errs++; $display("FAIL rd_ld_rvalid: got %b want 0", ld_rvalid); end
        @(negedge clk);
        #1;
        vecs++; if (cpu_rvalid !== 1'b0) begin errs++; $display("FAIL rd_rvalid_drop: got %b want 0", cpu_rvalid); end
        @(negedge clk);
    endtask

    task automatic test_pipelined_reads();
        logic exp_v;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                ld_req = 1'b1; ld_we = 1'b0; ld_addr = 9'(1 + i);
            end else begin
                ld_req = 1'b0;
            end
            exp_v = (i >= 1 && i <= 3);
            #1;
            if (i < 3) begin
                vecs++; if (ld_gnt !== 1'b1) begin errs++; $display("FAIL pipe_gnt[%0d]: got %b want 1", i, ld_gnt); end
            end
            vecs++; if (ld_rvalid !== exp_v) begin errs++; $display("FAIL pipe_rvalid[%0d]: got %b want %b", i, ld_rvalid, exp_v); end
            if (exp_v) begin
                vecs++; if (ld_rdata !== 16'(9 + i)) begin errs++; $display("FAIL pipe_rdata[%0d]: got %h want %h", i, ld_rdata, 16'(9 + i)); end
            end
            vecs++; if (cpu_rvalid !== 1'b0) begin errs++; $display("FAIL pipe_cpu_rvalid[%0d]: got %b want 0", i, cpu_rvalid); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_clear();
        resetN = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h040; cpu_wdata = 16'h0055;
        ld_req = 1'b0;
        #1;
        vecs++; if (ram_we !== 1'b0) begin errs++; $display("FAIL mid_rst_we0: got %b want 0", ram_we); end
        @(negedge clk);
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vecs++; if (ram_addr !== 9'(16 + i)) begin errs++; $display("FAIL mid_pre_addr[%0d]: got %h want %h", i, ram_addr, 9'(16 + i)); end
            if (i != 2) @(negedge clk);
        end
        resetN = 1'b0;
        #1;
        vecs++; if (ram_we !== 1'b0) begin errs++; $display("FAIL mid_rst_we1: got %b want 0", ram_we); end
        vecs++; if (ld_gnt !== 1'b0) begin errs++; $display("FAIL mid_rst_ld_gnt: got %b want 0", ld_gnt); end
        vecs++; if (cpu_stall !== 1'b1) begin errs++; $display("FAIL mid_rst_stall: got %b want 1", cpu_stall); end
        @(negedge clk);
        #1;
        vecs++; if (ram_we !== 1'b0) begin errs++; $display("FAIL mid_rst_we2: got %b want 0", ram_we); end
        resetN = 1'b1;
        #1;
        vecs++; if (ram_we !== 1'b1) begin errs++; $display("FAIL mid_restart_we: got %b want 1", ram_we); end
        vecs++; if (ram_addr !== 9'h010) begin errs++; $display("FAIL mid_restart_addr: got %h want 010", ram_addr); end
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            #1;
            vecs++; if (ram_addr !== 9'(16 + i)) begin errs++; $display("FAIL mid_addr[%0d]: got %h want %h", i, ram_addr, 9'(16 + i)); end
            vecs++; if (clear_busy !== 1'b1) begin errs++; $display("FAIL mid_busy[%0d]: got %b want 1", i, clear_busy); end
        end
        @(negedge clk);
        #1;
        vecs++; if (clear_busy !== 1'b0) begin errs++; $display("FAIL mid_busy_end: got %b want 0", clear_busy); end
        vecs++; if (cpu_stall !== 1'b0) begin errs++; $display("FAIL mid_cpu_gnt: got %b want 0", cpu_stall); end
        vecs++; if (ram_addr !== 9'h040) begin errs++; $display("FAIL mid_cpu_addr: got %h want 040", ram_addr); end
        cpu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_no_clear();
        resetN = 1'b0;
        b_cpu_req = 1'b1; b_cpu_we = 1'b1; b_cpu_addr = 9'h007; b_cpu_wdata = 16'h0077;
        #1;
        vecs++; if (b_ram_we !== 1'b0) begin errs++; $display("FAIL nc_rst_we: got %b want 0", b_ram_we); end
        @(negedge clk);
        #1;
        vecs++; if (b_clear_busy !== 1'b0) begin errs++; $display("FAIL nc_busy: got %b want 0", b_clear_busy); end
        vecs++; if (b_cpu_stall !== 1'b1) begin errs++; $display("FAIL nc_rst_stall: got %b want 1", b_cpu_stall); end
        resetN = 1'b1;
        #1;
        vecs++; if (b_ram_we !== 1'b1) begin errs++; $display("FAIL nc_we: got %b want 1", b_ram_we); end
        vecs++; if (b_cpu_stall !== 1'b0) begin errs++; $display("FAIL nc_stall: got %b want 0", b_cpu_stall); end
        vecs++; if (b_ram_addr !== 9'h007) begin errs++; $display("FAIL nc_addr: got %h want 007", b_ram_addr); end
        vecs++; if (b_ram_wdata !== 16'h0077) begin errs++; $display("FAIL nc_wdata: got %h want 0077", b_ram_wdata); end
        @(negedge clk);
        b_cpu_req = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
        mem[5] = 16'h1234;
        mem[1] = 16'h000A;
        mem[2] = 16'h000B;
        mem[3] = 16'h000C;
        test_reset();
        test_clear();
        test_contention();
        test_read_latency();
        test_pipelined_reads();
        test_reset_mid_clear();
        test_no_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Arbitrates the single CPU-side read/write port of the data RAM between the CPU and a second master, the program/data loader (e.g. a UART or switch loader). After reset it optionally runs a clear sequence that zeroes the screen region of RAM before any master is served. It sits between `cpu`, the loader and the `ram` CPU port; the screen read port is untouched.

## Interface
Parameters:
- DATA_WIDTH, 16, word width
- ADDR_WIDTH, 9, RAM address width (512 words)
- SCREEN_BASE, 0, first word cleared after reset
- SCREEN_WORDS, 384, number of words cleared; 0 disables clearing
- CLEAR_ON_RESET, 1, 1 = run the clear sequence after reset, 0 = go straight to ARB

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock (CLK_50 in top)
- resetN  in  1  synchronous active-low reset
- cpu_req  in  1  CPU access request, read or write
- cpu_we  in  1  1 = write, 0 = read (valid with cpu_req)
- cpu_addr  in  ADDR_WIDTH  CPU address
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_stall  out  1  cpu_req & ~cpu_gnt; CPU holds its request and PC
- cpu_rvalid  out  1  cpu_rdata valid this cycle
- cpu_rdata  out  DATA_WIDTH  read data (ram_rdata passthrough)
- ld_req, ld_we, ld_addr, ld_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  loader request, same meaning as the CPU signals
- ld_gnt  out  1  loader granted this cycle
- ld_rvalid  out  1  ld_rdata valid
- ld_rdata  out  DATA_WIDTH  read data (ram_rdata passthrough)
- ram_addr  out  ADDR_WIDTH  to ram addr
- ram_wdata  out  DATA_WIDTH  to ram wdata
- ram_we  out  1  to ram we
- ram_rdata  in  DATA_WIDTH  from ram rdata; valid 1 cycle after the address
- clear_busy  out  1  clear sequence in progress

## Operation
- States: CLEAR and ARB.
- Reset: state = CLEAR if (CLEAR_ON_RESET && SCREEN_WORDS != 0), else ARB.
  - clr_cnt = 0.
  - rr_last = LOADER, so the CPU wins the first tie.
  - rvalid flags = 0.
- CLEAR:
  - ram_we = 1, ram_addr = SCREEN_BASE + clr_cnt (truncated to ADDR_WIDTH), ram_wdata = 0.
  - clr_cnt increments each cycle. Leave to ARB on the cycle clr_cnt == SCREEN_WORDS-1 is written.
  - No grants in this state: cpu_stall = cpu_req, ld_gnt = 0, clear_busy = 1.
- ARB:
  - Only one requester: it is granted.
  - Both request: grant the one that is not rr_last. rr_last is updated on every grant.
  - Neither requests: ram_we = 0, ram_addr holds its last value, and no rvalid is scheduled.
  - Granted master drives ram_addr/ram_wdata; ram_we = granted master's we.
  - Write completes in the grant cycle.
  - Read: the owner's rvalid is registered and asserted in the next cycle. Back-to-back reads are pipelined, one per cycle.
- Address/data widths pass through unchanged; no arithmetic except clr_cnt, which is $clog2(SCREEN_WORDS+1) bits.
- ram_we, cpu_gnt (internal) and ld_gnt are forced to 0 combinationally whenever resetN is low, so no write reaches RAM during reset.
- Reset mid-CLEAR restarts the clear from SCREEN_BASE. Reset mid-read drops the pending rvalid.

## Timing
- Grant is combinational, in the same cycle as the request. cpu_stall is combinational from cpu_req and the arbitration result.
- Read latency: request at cycle N, rvalid and rdata at N+1.
- Clear duration: exactly SCREEN_WORDS cycles after the first clock edge with resetN high. clear_busy falls on the cycle after the last clear write.
- Reset values: ram_we 0, ram_addr 0, ram_wdata 0, ld_gnt 0, cpu_rvalid 0, ld_rvalid 0, clear_busy = CLEAR_ON_RESET && SCREEN_WORDS != 0.
- A master must hold req/we/addr/wdata stable until it is granted; changing them earlier is not supported.

## Structure
- Shared package `mem_pkg`:
  - typedef `master_e` {CPU, LOADER}.
  - typedef `arb_state_e` {CLEAR, ARB}.
  - DATA_WIDTH and ADDR_WIDTH defaults, shared with `ram` and `cpu`.
- One natural sub-module: `rr_arbiter2`, a 2-way round-robin grant with the rr_last register. The rest (clear counter, port mux, rvalid flags) lives in `ram_arbiter`.
- In top, `ram_arbiter` is inserted between `cpu_inst` and the `ram_data` CPU port, and cpu_stall is wired to the CPU's stall input.

## Test plan
- **Clear:** SCREEN_BASE=0x10, SCREEN_WORDS=4, release reset with cpu_req=1 → ram_we=1 at addr 0x10..0x13 with wdata 0 in 4 consecutive cycles; cpu_stall=1 throughout; clear_busy falls after the last write; CPU granted on the next cycle.
- **Contention:** both masters continuously request writes after the clear → grants alternate CPU, LOADER, CPU, LOADER; cpu_stall toggles 0,1,0,1.
- **Read latency:** RAM[5]=0x1234; CPU reads addr 5 at cycle N → cpu_rvalid=1 and cpu_rdata=0x1234 at N+1; ld_rvalid stays 0.
- **Pipelined reads:** loader reads addr 1,2,3 back-to-back with values 0xA,0xB,0xC → ld_rvalid high for 3 cycles with data 0xA,0xB,0xC.
- **Reset mid-clear:** assert resetN=0 when clr_cnt=2 → ram_we is 0 while reset is low; after release the clear restarts at SCREEN_BASE and runs the full SCREEN_WORDS cycles.
- **CLEAR_ON_RESET=0:** release reset → clear_busy=0 and a CPU write is granted in the first cycle.
